// File: rtl/rand_arb_pkg.sv
// Shared types and defaults for the random-word arbiter.
// Combinational content only; no latency or flow control of its own.
// Holds the buffer state enum, parameter defaults and the pointer-width helper.
package rand_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int WORD_W_DEF  = 30;
    localparam int CNT_W_DEF   = 8;
    localparam int MAX_AGE_DEF = 255;
    localparam int NUM_REQ_MAX = 8;

    // Width needed to index n requesters; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping upward.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_pick
    import rand_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic               o_any
);

    always_comb begin
        int         w_idx_int;
        logic [PTR_W-1:0] w_idx;
        o_pick    = '0;
        o_any     = 1'b0;
        w_idx_int = 0;
        w_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx_int = int'(i_ptr) + i;
            if (w_idx_int >= NUM_REQ) begin
                w_idx_int = w_idx_int - NUM_REQ;
            end
            w_idx = PTR_W'(w_idx_int);
            if (!o_any && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rand_word_arbiter.sv
// Hands each LFSR word from a 1-deep buffer to one requester, round-robin; RAND_AGE_LIMIT_EN adds expiry.
// Latency: rand_valid at edge E0 with req high gives a registered gnt/out_valid pulse after edge E0+1.
// Backpressure: none toward the generator; an unclaimed word is overwritten (freshest wins) and counted.
module rand_word_arbiter
    import rand_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_AGE = MAX_AGE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rand_valid,
    input  logic [WORD_W-1:0]  rand_word,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               out_valid,
    output logic [WORD_W-1:0]  out_word,
    output logic               buf_full,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int PTR_W = clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || MAX_AGE < 1) begin : g_param_check
        $error("rand_word_arbiter: NUM_REQ must be 2..%0d and MAX_AGE >= 1", NUM_REQ_MAX);
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WORD_W-1:0]    r_buf;
    logic [PTR_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_out_valid;
    logic [WORD_W-1:0]    r_out_word;
    logic [CNT_W-1:0]     r_drop_cnt;

    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_any;
    logic                 w_grant;
    logic                 w_load;
    logic                 w_drop;
    logic                 w_expire;
    logic [PTR_W-1:0]     w_winner;
    logic [PTR_W-1:0]     w_ptr_nxt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req  (req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    assign w_grant = (r_state == FULL) && w_any;

    always_comb begin
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_winner = PTR_W'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

`ifdef RAND_AGE_LIMIT_EN
    localparam int AGE_W = clog2(MAX_AGE + 1);

    logic [AGE_W-1:0] r_age;

    assign w_expire = (r_state == FULL) && (r_age == AGE_W'(MAX_AGE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (w_load) begin
            r_age <= '0;
        end else if (r_state == FULL && r_age != AGE_W'(MAX_AGE)) begin
            r_age <= r_age + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant beats both overwrite and expiry; a same-edge fresh word refills the buffer.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (rand_valid) begin
                    w_state_nxt = FULL;
                    w_load      = 1'b1;
                end
            end
            FULL: begin
                if (w_grant) begin
                    w_load = rand_valid;
                    if (!rand_valid) begin
                        w_state_nxt = EMPTY;
                    end
                end else if (rand_valid) begin
                    w_load = 1'b1;
                    w_drop = 1'b1;
                end else if (w_expire) begin
                    w_drop      = 1'b1;
                    w_state_nxt = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_load) begin
                r_buf <= rand_word;
            end
            r_gnt       <= w_grant ? w_pick : '0;
            r_out_valid <= w_grant;
            if (w_grant) begin
                r_out_word <= r_buf;
                r_ptr      <= w_ptr_nxt;
            end
            if (w_drop && r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign buf_full  = (r_state == FULL);
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_rand_word_arbiter.sv
// Scoreboard bench for rand_word_arbiter: expected grants queued at stimulus time, popped on out_valid.
// Age-limit expectations follow RAND_AGE_LIMIT_EN with MAX_AGE=3.
module tb_rand_word_arbiter;

    localparam int NR = 4;
    localparam int WW = 30;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rand_valid;
    logic [WW-1:0] rand_word;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic          out_valid;
    logic [WW-1:0] out_word;
    logic          buf_full;
    logic [CW-1:0] drop_cnt;

    typedef struct packed {
        logic [NR-1:0] g;
        logic [WW-1:0] w;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rand_word_arbiter #(
        .NUM_REQ (NR),
        .WORD_W  (WW),
        .CNT_W   (CW),
        .MAX_AGE (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rand_valid (rand_valid),
        .rand_word  (rand_word),
        .req        (req),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_word   (out_word),
        .buf_full   (buf_full),
        .drop_cnt   (drop_cnt)
    );

    // Every delivered word must match the head of the scoreboard; idle cycles must show no grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            vectors++;
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_unexpected: got gnt=%b word=%h, none was due", gnt, out_word);
                end else begin
                    e = sb.pop_front();
                    if (gnt !== e.g || out_word !== e.w) begin
                        miscompares++;
                        $display("FAIL grant: got gnt=%b word=%h, want gnt=%b word=%h",
                                 gnt, out_word, e.g, e.w);
                    end
                end
            end else if (gnt !== '0) begin
                miscompares++;
                $display("FAIL gnt_idle: got gnt=%b with out_valid=%b, want 0000", gnt, out_valid);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [WW-1:0] w);
        rand_valid = 1'b1;
        rand_word  = w;
        tick(1);
        rand_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [NR-1:0] g, input logic [WW-1:0] w);
        exp_t e;
        e.g = g;
        e.w = w;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        rand_valid = 1'b0;
        rand_word  = '0;
        req        = '0;
        #12;
        vectors++;
        if ({gnt, out_valid, buf_full, drop_cnt, out_word} !== '0) begin
            miscompares++;
            $display("FAIL reset_init: got gnt=%b ov=%b full=%b drop=%h word=%h, want all 0",
                     gnt, out_valid, buf_full, drop_cnt, out_word);
        end
        rst_n = 1'b1;
        tick(1);
        // Grant to req[0] moves the pointer to 1; reset must bring it back to 0.
        req = 4'b0001;
        load_word(30'h3C);
        tick(1);
        vectors++;
        if (out_valid !== 1'b1 || gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_pregrant: got ov=%b gnt=%b, want 1 0001", out_valid, gnt);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({gnt, out_valid, buf_full, drop_cnt, out_word} !== '0) begin
            miscompares++;
            $display("FAIL reset_midgrant: got gnt=%b ov=%b full=%b drop=%h word=%h, want all 0",
                     gnt, out_valid, buf_full, drop_cnt, out_word);
        end
        #3;
        rst_n = 1'b1;
        req   = '0;
        tick(1);
        req = 4'b0011;
        push_exp(4'b0001, 30'h2A5);
        load_word(30'h2A5);
        tick(1);
        req = '0;
        tick(2);
    endtask

    task automatic test_single();
        req = 4'b0010;
        push_exp(4'b0010, 30'h000000B);
        load_word(30'h000000B);
        vectors++;
        if (buf_full !== 1'b1) begin
            miscompares++;
            $display("FAIL single_full: got buf_full=%b, want 1", buf_full);
        end
        tick(1);
        req = '0;
        vectors++;
        if (out_valid !== 1'b1 || gnt !== 4'b0010 || out_word !== 30'h000000B) begin
            miscompares++;
            $display("FAIL single_grant: got ov=%b gnt=%b word=%h, want 1 0010 000000b",
                     out_valid, gnt, out_word);
        end
        tick(1);
        vectors++;
        if (buf_full !== 1'b0 || out_valid !== 1'b0 || out_word !== 30'h000000B) begin
            miscompares++;
            $display("FAIL single_after: got full=%b ov=%b word=%h, want 0 0 000000b",
                     buf_full, out_valid, out_word);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push_exp(NR'(1 << (i % 4)), WW'(32'h1000 + i));
            load_word(WW'(32'h1000 + i));
            tick(30);
        end
        req = 4'b0101;
        push_exp(4'b0100, 30'h2000);
        load_word(30'h2000);
        tick(5);
        push_exp(4'b0001, 30'h2001);
        load_word(30'h2001);
        tick(5);
        req = '0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rr_pending: got %0d grants outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_collision();
        req = '0;
        load_word(30'hA);
        req = 4'b0010;
        push_exp(4'b0010, 30'hA);
        load_word(30'h5);
        req = '0;
        vectors++;
        if (buf_full !== 1'b1 || drop_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL collision_state: got full=%b drop=%h, want 1 00", buf_full, drop_cnt);
        end
        tick(2);
        req = 4'b0100;
        push_exp(4'b0100, 30'h5);
        tick(2);
        req = '0;
        vectors++;
        if (buf_full !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_drain: got buf_full=%b, want 0", buf_full);
        end
    endtask

    task automatic test_overrun();
        req = '0;
        load_word(30'h1);
        load_word(30'h2);
        vectors++;
        if (drop_cnt !== 8'h01 || buf_full !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_one: got drop=%h full=%b, want 01 1", drop_cnt, buf_full);
        end
        req = 4'b1000;
        push_exp(4'b1000, 30'h2);
        tick(2);
        req = '0;
        load_word(30'h100);
        for (int i = 0; i < 256; i++) begin
            load_word(WW'(32'h200 + i));
            if (i == 99) begin
                vectors++;
                if (drop_cnt !== 8'd101) begin
                    miscompares++;
                    $display("FAIL overrun_mid: got drop=%0d, want 101", drop_cnt);
                end
            end
        end
        vectors++;
        if (drop_cnt !== 8'hFF || buf_full !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sat: got drop=%h full=%b, want ff 1", drop_cnt, buf_full);
        end
        req = 4'b0001;
        push_exp(4'b0001, 30'h2FF);
        tick(2);
        req = '0;
    endtask

    task automatic test_age();
        logic          exp_full;
        logic [CW-1:0] exp_drop;
        apply_reset();
        req = '0;
        load_word(30'h77);
        tick(3);
        vectors++;
        if (buf_full !== 1'b1) begin
            miscompares++;
            $display("FAIL age_hold: got buf_full=%b, want 1", buf_full);
        end
        tick(1);
`ifdef RAND_AGE_LIMIT_EN
        exp_full = 1'b0;
        exp_drop = 8'h01;
`else
        exp_full = 1'b1;
        exp_drop = 8'h00;
`endif
        vectors++;
        if (buf_full !== exp_full || drop_cnt !== exp_drop) begin
            miscompares++;
            $display("FAIL age_expire: got full=%b drop=%h, want %b %h",
                     buf_full, drop_cnt, exp_full, exp_drop);
        end
        tick(10);
        vectors++;
        if (buf_full !== exp_full) begin
            miscompares++;
            $display("FAIL age_long: got buf_full=%b, want %b", buf_full, exp_full);
        end
`ifndef RAND_AGE_LIMIT_EN
        req = 4'b0001;
        push_exp(4'b0001, 30'h77);
        tick(2);
        req = '0;
`endif
        // Request arrives exactly on the edge where the age limit is reached.
        load_word(30'h99);
        tick(3);
        req = 4'b0010;
        push_exp(4'b0010, 30'h99);
        tick(1);
        req = '0;
        tick(1);
        vectors++;
        if (buf_full !== 1'b0 || drop_cnt !== exp_drop) begin
            miscompares++;
            $display("FAIL age_grant_wins: got full=%b drop=%h, want 0 %h",
                     buf_full, drop_cnt, exp_drop);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_collision();
        test_overrun();
        test_age();
        tick(3);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL final_pending: got %0d grants never delivered, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
